// File: rtl/y_pc_fetch_if.sv
// ============================================================================
// y_pc_fetch_if : fetch-address handshake and redirect bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface y_pc_fetch_if #(
    parameter int WIDTH = 32
);
    logic             pc_valid;
    logic [WIDTH-1:0] pc;
    logic             pc_ready;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;

    modport master (
        output pc_valid,
        output pc,
        input  pc_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  pc_valid,
        input  pc,
        output pc_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

`default_nettype wire

// File: rtl/y_pc_fetch.sv
// ============================================================================
// y_pc_fetch : PC register, next-PC select and valid/ready issue control
// Revision: 1.0
// ============================================================================
`default_nettype none

module y_pc_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               STEP     = 4,
    parameter int               CNTW     = 16
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    input  wire logic            start_i,
    input  wire logic            halt_i,
    y_pc_fetch_if.master         bus,
    output logic [CNTW-1:0]      issued_o,
    output logic                 running_o
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNTW-1:0]  issued_q, issued_d;
    logic             fire;

    assign fire = valid_q & bus.pc_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)             state_d = RUN;
            RUN:     if (halt_i)              state_d = HALTED;
            HALTED:  if (start_i && !halt_i)  state_d = RUN;
            default:                          state_d = IDLE;
        endcase

        // Redirect overrides the sequential step even when the old PC is accepted.
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (fire) begin
            pc_d = pc_q + STEP_W;
        end else begin
            pc_d = pc_q;
        end

        issued_d = issued_q + CNTW'(fire);
        valid_d  = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            pc_q     <= RESET_PC;
            issued_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            issued_q <= issued_d;
        end
    end

    assign bus.pc_valid = valid_q;
    assign bus.pc       = pc_q;
    assign issued_o     = issued_q;
    assign running_o    = valid_q;

endmodule

`default_nettype wire
